onchip_mem_arbiter: RTL



---
 rtl/onchip_mem_arbiter_pkg.sv | 14 +
 rtl/onchip_mem_arbiter_if.sv | 24 ++
 rtl/onchip_mem_arbiter_rr2.sv | 45 ++++
 rtl/onchip_mem_arbiter.sv | 90 +++++++++
 4 files changed

// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared types and defaults for the two-master on-chip RAM arbiter.
package onchip_arb_pkg;

  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DATA_W = 32;

  typedef logic master_id_t;

  typedef struct packed {
    logic       valid;
    master_id_t owner;
  } rd_tag_t;

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Pipelined Avalon-MM link between one master and the arbiter.
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_mem_arbiter_rr2.sv
// Two-way grant logic. Round-robin on ties by default; ONCHIP_ARB_FIXED_PRIO_EN
// selects fixed priority (m0 always wins) and drops the last_grant register.
module onchip_arb_rr2
  import onchip_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef ONCHIP_ARB_FIXED_PRIO_EN

  always_comb begin
    gnt    = '0;
    gnt[0] = req[0];
    gnt[1] = req[1] & ~req[0];
  end

`else

  master_id_t last_grant_q, last_grant_d;

  // on a tie the master that did not win last time goes next
  always_comb begin
    gnt    = '0;
    gnt[0] = req[0] & (~req[1] | (last_grant_q == 1'b1));
    gnt[1] = req[1] & (~req[0] | (last_grant_q == 1'b0));
    last_grant_d = last_grant_q;
    if (gnt[0])
      last_grant_d = 1'b0;
    else if (gnt[1])
      last_grant_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      last_grant_q <= 1'b1;
    else
      last_grant_q <= last_grant_d;
  end

`endif

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two pipelined Avalon-MM masters sharing one single-port on-chip RAM.
// Grant policy lives in onchip_arb_rr2 (see ONCHIP_ARB_FIXED_PRIO_EN there).
module onchip_mem_arbiter
  import onchip_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  onchip_mem_arbiter_if.slave m0,
  onchip_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic [1:0] req, gnt;
  rd_tag_t    rd_push, pipe_out;
  rd_tag_t    pipe_q [RD_LAT];
  rd_tag_t    pipe_d [RD_LAT];

  // requests are masked in reset so nothing reaches the RAM or the pipe
  assign req[0] = (m0.read | m0.write) & reset_n;
  assign req[1] = (m1.read | m1.write) & reset_n;

  onchip_arb_rr2 u_rr2 (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (gnt)
  );

  always_comb begin
    mem_chipselect = |gnt;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    rd_push        = '0;
    if (gnt[0]) begin
      mem_write      = m0.write;
      mem_address    = m0.address;
      mem_byteenable = m0.byteenable;
      mem_writedata  = m0.writedata;
      rd_push.valid  = m0.read & ~m0.write;
      rd_push.owner  = 1'b0;
    end else if (gnt[1]) begin
      mem_write      = m1.write;
      mem_address    = m1.address;
      mem_byteenable = m1.byteenable;
      mem_writedata  = m1.writedata;
      rd_push.valid  = m1.read & ~m1.write;
      rd_push.owner  = 1'b1;
    end
  end

  // read-return tag pipe, one stage per cycle of RAM read latency
  always_comb begin
    pipe_d[0] = rd_push;
    for (int i = 1; i < RD_LAT; i++)
      pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++)
        pipe_q[i] <= '0;
    end else begin
      for (int i = 0; i < RD_LAT; i++)
        pipe_q[i] <= pipe_d[i];
    end
  end

  assign pipe_out = pipe_q[RD_LAT-1];

  assign m0.waitrequest   = ~reset_n | (req[0] & ~gnt[0]);
  assign m1.waitrequest   = ~reset_n | (req[1] & ~gnt[1]);
  assign m0.readdatavalid = pipe_out.valid & (pipe_out.owner == 1'b0);
  assign m1.readdatavalid = pipe_out.valid & (pipe_out.owner == 1'b1);
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;
  assign mem_clken        = 1'b1;

endmodule
